// File: rtl/keypad_scanner_pkg.sv
// Shared types, sizes and helpers for the 4x4 keypad scanner.
package keypad_scanner_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        REPORT   = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam int          KEY_W    = 4;
    localparam int          ROWS     = 4;
    localparam int          COLS     = 4;
    localparam logic [3:0]  ROW_IDLE = 4'b1110;

    // Index of the lowest active-low column; column 0 has the highest priority.
    // Callers only use the result when at least one column is low.
    function automatic logic [1:0] lowest_zero(input logic [COLS-1:0] col);
        lowest_zero = 2'd0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (!col[i]) begin
                lowest_zero = 2'(i);
            end
        end
    endfunction

    // Active-low one-cold row drive for a given row index.
    function automatic logic [ROWS-1:0] row_drive(input logic [1:0] idx);
        row_drive = ~((~ROW_IDLE) << idx);
    endfunction

endpackage

// File: rtl/keypad_scanner_tick_sync.sv
// Turns every edge of the divided scan clock into a one-cycle tick in the
// system clock domain. The divided clock is only ever sampled as data.
module tick_sync (
    input  logic clk_in,
    input  logic rst_n,
    input  logic slow_clk_i,
    output logic tick_o
);

    // Two metastability stages followed by one history stage.
    logic [2:0] sync_q;

    // Shift the sampled divided clock through the three flops; idle level is 1.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], slow_clk_i};
        end
    end

    // Any difference between the synchronized value and its history is an edge.
    assign tick_o = sync_q[1] ^ sync_q[2];

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the rows once per scan tick, debounces the
// columns over DEBOUNCE_TICKS ticks and reports one code per key press.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int CNT_W          = 3
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             slow_clk,
    input  logic [COLS-1:0]  col_n,
    output logic [ROWS-1:0]  row_n,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held
);

    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_TICKS);

    logic tick;

    tick_sync u_tick_sync (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .slow_clk_i (slow_clk),
        .tick_o     (tick)
    );

    logic [COLS-1:0]  col_meta_q, col_s_q;
    state_t           state_q, state_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [KEY_W-1:0] key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;
    logic             all_high;
    logic [1:0]       win_col;

    // Bring the asynchronous columns into the clk_in domain; idle level is all-high.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_q <= '1;
            col_s_q    <= '1;
        end else begin
            col_meta_q <= col_n;
            col_s_q    <= col_meta_q;
        end
    end

    assign all_high = (col_s_q == '1);
    assign win_col  = lowest_zero(col_s_q);
    // The counter never wraps: it holds once it reaches the accept threshold.
    assign cnt_inc  = (cnt_q >= CNT_DONE) ? cnt_q : cnt_q + 1'b1;

    // Scanner state register and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SCAN;
            row_idx_q   <= '0;
            col_idx_q   <= '0;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    // Next-state logic: every move except leaving REPORT waits for a scan tick.
    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        col_idx_d   = col_idx_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        case (state_q)
            SCAN: begin
                if (tick) begin
                    if (all_high) begin
                        row_idx_d = row_idx_q + 1'b1;
                    end else begin
                        col_idx_d = win_col;
                        cnt_d     = CNT_W'(1);
                        state_d   = DEBOUNCE;
                    end
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (!all_high && (win_col == col_idx_q)) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= CNT_DONE) begin
                            state_d = REPORT;
                        end
                    end else begin
                        cnt_d     = '0;
                        row_idx_d = row_idx_q + 1'b1;
                        state_d   = SCAN;
                    end
                end
            end
            REPORT: begin
                // Code, strobe and held flag all become visible on the same edge.
                key_code_d  = {row_idx_q, col_idx_q};
                key_valid_d = 1'b1;
                key_held_d  = 1'b1;
                cnt_d       = '0;
                state_d     = RELEASE;
            end
            RELEASE: begin
                if (tick) begin
                    if (all_high) begin
                        if (cnt_inc >= CNT_DONE) begin
                            key_held_d = 1'b0;
                            cnt_d      = '0;
                            row_idx_d  = row_idx_q + 1'b1;
                            state_d    = SCAN;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    assign row_n     = row_drive(row_idx_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- 4x4 matrix keypad scanner for the calculator front end.
- Sits directly downstream of the slow-clock divider and consumes its divided clock output as a scan-rate timebase.
- The divided clock is never used as a clock. Each transition is detected in the system clock domain and becomes a one-cycle scan tick.
- Drives rows one at a time, debounces the columns, and reports one code per key press to the operand/operator logic.

Parameters:
- DEBOUNCE_TICKS, 4: consecutive stable ticks required to accept a press and to accept a release.
- CNT_W, 3: width of the debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_TICKS.

Ports:
- clk_in  input  1  system clock; the only clock in the block.
- rst_n  input  1  asynchronous active-low reset.
- slow_clk  input  1  divided clock from the divider, treated as data. Every edge, rising or falling, is one scan tick.
- col_n  input  4  keypad columns, active-low with external pull-ups, asynchronous to clk_in.
- row_n  output  4  keypad row drive, active-low, exactly one bit low at all times.
- key_code  output  4  code of the last accepted key, computed as row_index*4 + col_index.
- key_valid  output  1  one-clk_in-cycle pulse when key_code updates.
- key_held  output  1  high from accept until the release is debounced.

Behaviour:
- Reset (asynchronous, all outputs): row_n=4'b1110, row_index=0, key_code=0, key_valid=0, key_held=0, state=SCAN, counters=0, synchronizer flops=1 (idle level).
- Tick generation:
  - slow_clk passes through a 2-FF synchronizer, then a third flop; tick = ff2 XOR ff3.
  - Tick asserts 3 clk_in cycles after a slow_clk edge and lasts exactly 1 cycle.
- col_n passes through its own 2-FF synchronizer (col_s).
- All state transitions occur only on clk_in cycles where tick=1, except REPORT, which takes exactly one clk_in cycle.
- Column priority: if several col_s bits are low, the lowest index wins (col 0 highest priority).
- SCAN state (on tick):
  - col_s==4'hF: row_index increments mod 4 (3 wraps to 0), row_n updates, stay in SCAN.
  - col_s!=4'hF: latch col_index by priority, cnt=1, go to DEBOUNCE. Row stays frozen.
- DEBOUNCE state (on tick):
  - Winning column equals the latched column: cnt++. When cnt reaches DEBOUNCE_TICKS, go to REPORT.
  - col_s==4'hF or a different winning column: cnt=0, advance row, go to SCAN.
- REPORT state (single cycle, not tick-gated):
  - key_code <= {row_index[1:0], col_index[1:0]}, key_valid=1, key_held<=1, then go to RELEASE.
- RELEASE state (on tick):
  - col_s==4'hF: cnt++; any other value: cnt=0.
  - When cnt reaches DEBOUNCE_TICKS: key_held<=0, cnt=0, advance row, go to SCAN.
  - No new key is reported while in RELEASE, including a second key pressed while the first is held.
- key_code holds its value until the next REPORT.
- key_valid is high only in the REPORT cycle.
- Press latency: exactly DEBOUNCE_TICKS ticks after the first sampled low, plus 1 clk_in cycle.
- Tick during REPORT cannot occur, because ticks are at least 3 clk_in cycles apart. If slow_clk toggles faster than that, ticks may be lost; this is not a supported configuration.
- Reset mid-debounce or mid-release: no key_valid is emitted, and the block restarts at row 0.
- The counter saturates logic; it is never allowed to wrap.

Decomposition:
- Shared package/include:
  - state encoding: SCAN=2'd0, DEBOUNCE=2'd1, REPORT=2'd2, RELEASE=2'd3
  - KEY_W=4, ROWS=4, COLS=4
  - ROW_IDLE=4'b1110
- One sub-module, tick_sync: 3-flop synchronizer plus edge detector (slow_clk → tick), reset to 1.
- Reuse the same synchronizer pattern for col_n inside the top level.

Test Plan:
- Idle scan: hold col_n=4'hF and toggle slow_clk every 20 clk_in cycles.
  - Expected: row_n sequence 1110→1101→1011→0111→1110, one step per tick.
  - Expected: key_valid never asserts.
- Clean press: hold col_n=4'b1101 while row 2 is driven, for 6 ticks.
  - Expected: one key_valid pulse with key_code=4'd9, then key_held=1.
  - On release to 4'hF: key_held falls 4 ticks later and scanning resumes at row 3.
- Bounce rejection: col 1 low for 2 ticks, high for 1 tick, then low for 4 ticks.
  - Expected: no report on the first burst.
  - Expected: exactly one key_valid after the stable run. The row counter advanced on the dropout, so the code reflects the row driven when the stable run began.
- Multi-column priority: col_n=4'b0110 on row 0, held stable.
  - Expected: key_code=4'd0.
- Hold and second key: keep key 9 held and add a press on col 3 during RELEASE.
  - Expected: no second key_valid until all columns have read high for 4 consecutive ticks.
- Async reset mid-DEBOUNCE: assert rst_n=0 between clock edges.
  - Expected: row_n=1110, key_held=0, key_valid=0 immediately.
  - Expected: no spurious key_valid after rst_n returns to 1.
